seq_detect_ctrl: RTL and testbench
==================================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: in_valid  input  1  word offer from requester.
REQ-004 SHALL: in_ready  output  1  controller accepts word (high only in IDLE).
REQ-005 SHALL: in_word  input  8  word to scan, sampled when in_valid && in_ready.
REQ-006 SHALL: in_lsb_first  input  1  bit order for scan (0 = MSB first), sampled with in_word.
REQ-007 SHALL: det_clr  output  1  active-high reset to the external Moore 1011 detector.
REQ-008 SHALL: det_seq  output  1  serial bit driven to the detector's seq_in.
REQ-009 SHALL: det_detect  input  1  detector's registered detect output.
REQ-010 SHALL: out_valid  output  1  result available.
REQ-011 SHALL: out_ready  input  1  consumer accepts result.
REQ-012 SHALL: out_count  output  4  number of detect pulses seen for the word.
REQ-013 SHALL: busy  output  1  high whenever state != IDLE.

Function
REQ-014 SHALL: FSM states IDLE, CLR, SHIFT, DRAIN, RESP, encoded one-hot.
REQ-015 SHALL: IDLE -> CLR on in_valid && in_ready; word, bit order latched; out_count zeroed.
REQ-016 SHALL: CLR lasts 1 cycle; det_clr = 1; det_seq = 0; -> SHIFT.
REQ-017 SHALL: SHIFT lasts exactly 8 cycles; cycle k drives det_seq = word bit k in the latched order (MSB first: bit 7-k; LSB first: bit k); -> DRAIN.
REQ-018 SHALL: DRAIN lasts exactly 2 cycles with det_seq = 0, covering the detector's 2-cycle latency from the last pattern bit to detect_out; -> RESP.
REQ-019 SHALL: det_detect sampled each SHIFT and DRAIN cycle; count += 1 per high cycle, saturating at 15; ignored in IDLE, CLR, RESP.
REQ-020 SHALL: RESP holds out_valid = 1 and out_count stable until out_ready; -> IDLE on the out_valid && out_ready cycle.
REQ-021 SHALL: in_ready = 1 only in IDLE; no word accepted while busy; no combinational path from in_valid to in_ready.
REQ-022 SHALL: out_valid and out_count registered; out_count holds last result after RESP until the next accept.
REQ-023 SHALL: end-to-end latency accept -> out_valid = 12 cycles (1 CLR + 8 SHIFT + 2 DRAIN + 1 register).
REQ-024 SHALL: out_ready held high before RESP has no effect; out_ready low stalls indefinitely in RESP with no detector activity.
REQ-025 SHALL: detector context never carries across words; CLR always precedes SHIFT.

Reset
REQ-026 SHALL: reset_n low asynchronously forces IDLE, out_valid = 0, out_count = 0, det_seq = 0, busy = 0, word/order registers = 0.
REQ-027 SHALL: det_clr = 1 while reset_n is low (combinational OR with CLR state) so the detector resets with the controller.
REQ-028 SHALL: reset mid-SHIFT/DRAIN/RESP abandons the word; no out_valid produced for it.

Structure
REQ-029 SHALL: package seq_det_pkg holds state enum type, WORD_W = 8, DRAIN_CYC = 2, CNT_W = 4.
REQ-030 SHALL: one sub-module seq_det_shifter (load, order select, 3-bit bit index, serial out) instantiated by the controller.
REQ-031 SHALL: formal properties: $onehot(state); in_ready -> state == IDLE; out_valid stable until out_ready; busy == !IDLE.

Verification
REQ-032 SHALL: in_word 8'b1011_0000, MSB first -> det_seq 1,0,1,1,0,0,0,0; out_count = 1; out_valid 12 cycles after accept.
REQ-033 SHALL: in_word 8'b0000_1011, MSB first -> detect arrives in 2nd DRAIN cycle; out_count = 1.
REQ-034 SHALL: in_word 8'b1011_1011, MSB first -> non-overlap (S4 consumes bit 4); out_count = 1; same word LSB first (bits 1,1,0,1,1,1,0,1) -> out_count = 1.
REQ-035 SHALL: in_word 8'h00 then 8'hFF back-to-back with out_ready = 1 -> out_count 0 then 0; second in_ready only after first RESP handshake.
REQ-036 SHALL: out_ready low 20 cycles in RESP -> out_valid and out_count stable, in_ready = 0 throughout.
REQ-037 SHALL: reset_n pulsed low at SHIFT cycle 3 of 8'b1011_0000 -> immediate IDLE, det_clr = 1 during reset, no out_valid; next word 8'b1011_0000 -> out_count = 1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 1011-detector sequencing controller.
`timescale 1ns/1ps
package seq_det_pkg;

    localparam int WORD_W    = 8;
    localparam int DRAIN_CYC = 2;
    localparam int CNT_W     = 4;
    localparam int IDX_W     = $clog2(WORD_W);
    localparam int DRN_W     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    // One-hot controller states
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_CLR   = 5'b00010,
        ST_SHIFT = 5'b00100,
        ST_DRAIN = 5'b01000,
        ST_RESP  = 5'b10000
    } state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/seq_det_shifter.sv
// Holds the accepted word and serialises it one bit per advance, in either order.
`timescale 1ns/1ps
module seq_det_shifter
    import seq_det_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [WORD_W-1:0] word_in,
    input  logic              lsb_first_in,
    input  logic              advance,
    output logic              ser_out,
    output logic              last
);

    logic [WORD_W-1:0] word_q, word_d;
    logic              lsb_q, lsb_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // Load restarts the bit index; advance steps it (wrapping after the last bit)
    always_comb begin
        word_d = word_q;
        lsb_d  = lsb_q;
        idx_d  = idx_q;
        if (load) begin
            word_d = word_in;
            lsb_d  = lsb_first_in;
            idx_d  = '0;
        end else if (advance) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // Word, order and index registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            lsb_q  <= 1'b0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            lsb_q  <= lsb_d;
            idx_q  <= idx_d;
        end
    end

    // Bit k of the scan: word[k] when LSB first, word[W-1-k] when MSB first
    always_comb begin
        ser_out = lsb_q ? word_q[idx_q] : word_q[IDX_W'(WORD_W-1) - idx_q];
        last    = (idx_q == IDX_W'(WORD_W-1));
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Feeds one word at a time through an external Moore 1011 detector and counts its
// detect pulses, returning the count over a valid/ready handshake.
`timescale 1ns/1ps
module seq_detect_ctrl
    import seq_det_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_lsb_first,
    output logic              det_clr,
    output logic              det_seq,
    input  logic              det_detect,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ov_q, ov_d;
    logic [DRN_W-1:0] drn_q, drn_d;
    logic             sh_load, sh_adv, sh_bit, sh_last;

    seq_det_shifter u_shifter (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (sh_load),
        .word_in      (in_word),
        .lsb_first_in (in_lsb_first),
        .advance      (sh_adv),
        .ser_out      (sh_bit),
        .last         (sh_last)
    );

    // Next-state, counter and result-valid logic; detect only counts in SHIFT/DRAIN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        drn_d   = drn_q;
        sh_load = 1'b0;
        sh_adv  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_CLR;
                    cnt_d   = '0;
                    sh_load = 1'b1;
                end
            end
            ST_CLR: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sh_adv = 1'b1;
                if (det_detect) cnt_d = sat_inc(cnt_q);
                if (sh_last) begin
                    state_d = ST_DRAIN;
                    drn_d   = DRN_W'(DRAIN_CYC - 1);
                end
            end
            ST_DRAIN: begin
                if (det_detect) cnt_d = sat_inc(cnt_q);
                if (drn_q == '0) begin
                    state_d = ST_RESP;
                    ov_d    = 1'b1;
                end else begin
                    drn_d = drn_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    ov_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ov_d    = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            drn_q   <= drn_d;
        end
    end

    // Output decode from flops only; reset also clears the detector
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        det_clr   = !reset_n || (state_q == ST_CLR);
        det_seq   = (state_q == ST_SHIFT) && sh_bit;
        out_valid = ov_q;
        out_count = cnt_q;
    end

    a_onehot:   assert property (@(posedge clk) disable iff (!reset_n) $onehot(state_q));
    a_rdy_idle: assert property (@(posedge clk) disable iff (!reset_n) in_ready |-> state_q == ST_IDLE);
    a_ov_hold:  assert property (@(posedge clk) disable iff (!reset_n)
                                 out_valid && !out_ready |=> out_valid && $stable(out_count));
    a_busy:     assert property (@(posedge clk) disable iff (!reset_n) busy == (state_q != ST_IDLE));

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Random and directed words against a 1011-count reference; includes a Moore
// detector model standing in for the external detector.
`timescale 1ns/1ps
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid, in_ready, in_lsb_first;
    logic [7:0] in_word;
    logic       det_clr, det_seq, det_detect;
    logic       out_valid, out_ready, busy;
    logic [3:0] out_count;

    int n_chk = 0;
    int n_fail = 0;

    seq_detect_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_word      (in_word),
        .in_lsb_first (in_lsb_first),
        .det_clr      (det_clr),
        .det_seq      (det_seq),
        .det_detect   (det_detect),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_count    (out_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // External Moore 1011 detector: state = matched prefix length, S4 consumes the
    // following bit, detect registered one cycle after S4 is reached
    int dst;
    always @(posedge clk or posedge det_clr) begin
        if (det_clr) begin
            dst        <= 0;
            det_detect <= 1'b0;
        end else begin
            det_detect <= (dst == 4);
            case (dst)
                0:       dst <= det_seq ? 1 : 0;
                1:       dst <= det_seq ? 1 : 2;
                2:       dst <= det_seq ? 3 : 0;
                3:       dst <= det_seq ? 4 : 2;
                default: dst <= 0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Non-overlapping 1011 occurrences in scan order; a match also swallows the next bit
    function automatic int ref_count(input logic [7:0] w, input logic lsb);
        int b[8];
        int s, n;
        for (int k = 0; k < 8; k++) b[k] = lsb ? int'(w[k]) : int'(w[7-k]);
        s = 0;
        n = 0;
        while (s <= 4) begin
            if (b[s] == 1 && b[s+1] == 0 && b[s+2] == 1 && b[s+3] == 1) begin
                n++;
                s += 5;
            end else begin
                s++;
            end
        end
        return n;
    endfunction

    task automatic accept(input logic [7:0] w, input logic lsb, input logic pre_rdy, output bit ok);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("in_ready_idle", in_ready, 1);
        ok = in_ready;
        if (!ok) return;
        in_valid     = 1'b1;
        in_word      = w;
        in_lsb_first = lsb;
        out_ready    = pre_rdy;
        @(posedge clk);
    endtask

    task automatic run_word(input logic [7:0] w, input logic lsb, input logic pre_rdy, input int stall);
        int  exp_cnt;
        bit  ok;
        exp_cnt = ref_count(w, lsb);
        accept(w, lsb, pre_rdy, ok);
        if (!ok) return;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("in_ready_busy", in_ready, 0);
            if (c == 1) begin
                in_valid     = 1'b0;
                in_word      = 8'($urandom);
                in_lsb_first = 1'($urandom);
                chk("clr_pulse", det_clr, 1);
                chk("busy", busy, 1);
            end else begin
                chk("clr_off", det_clr, 0);
            end
            if (c >= 2 && c <= 9)
                chk("det_seq", det_seq, lsb ? w[c-2] : w[9-c]);
            if (c >= 10 && c <= 11)
                chk("drain_seq", det_seq, 0);
            if (c < 12) begin
                chk("ov_early", out_valid, 0);
            end else begin
                chk("ov_latency", out_valid, 1);
                chk("count", out_count, exp_cnt);
            end
        end
        if (!pre_rdy) begin
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("stall_ov", out_valid, 1);
                chk("stall_cnt", out_count, exp_cnt);
                chk("stall_rdy", in_ready, 0);
                chk("stall_seq", det_seq, 0);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("ov_cleared", out_valid, 0);
        chk("idle_rdy", in_ready, 1);
        chk("cnt_held", out_count, exp_cnt);
        out_ready = 1'($urandom);
    endtask

    initial begin
        bit seen_ov;
        bit ok;
        logic [7:0] w;
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_word      = 8'h00;
        in_lsb_first = 1'b0;
        out_ready    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_cnt", out_count, 0);
        chk("rst_clr", det_clr, 1);
        chk("rst_seq", det_seq, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_clr", det_clr, 0);

        // Directed words
        run_word(8'b1011_0000, 1'b0, 1'b0, 0);
        run_word(8'b0000_1011, 1'b0, 1'b0, 0);
        run_word(8'b1011_1011, 1'b0, 1'b0, 3);
        run_word(8'b1011_1011, 1'b1, 1'b0, 0);
        run_word(8'h00, 1'b0, 1'b1, 0);
        run_word(8'hFF, 1'b0, 1'b1, 0);
        run_word(8'b1011_0000, 1'b0, 1'b0, 20);

        // Reset during SHIFT cycle 3 abandons the word
        accept(8'b1011_0000, 1'b0, 1'b1, ok);
        if (ok) begin
            @(negedge clk);
            in_valid = 1'b0;
            repeat (4) @(negedge clk);
            reset_n = 1'b0;
            #1;
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_clr", det_clr, 1);
            chk("mid_rst_seq", det_seq, 0);
            chk("mid_rst_ov", out_valid, 0);
            chk("mid_rst_cnt", out_count, 0);
            @(negedge clk);
            reset_n = 1'b1;
            seen_ov = 1'b0;
            repeat (15) begin
                @(negedge clk);
                if (out_valid) seen_ov = 1'b1;
            end
            chk("no_ov_after_rst", seen_ov, 0);
        end
        run_word(8'b1011_0000, 1'b0, 1'b0, 0);

        // Random words, half of them seeded with a 1011 at a random offset
        for (int i = 0; i < 40; i++) begin
            w = 8'($urandom);
            if ($urandom_range(1)) begin
                int p = $urandom_range(4);
                w[p +: 4] = 4'b1011;
            end
            run_word(w, 1'($urandom), 1'($urandom), $urandom_range(5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
